// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, address-field
// widths and the wait-state counter width.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int WORD_OFF_BITS = 2;
  localparam int LAT_W         = 4;
  localparam int DEPTH_DEFAULT = 64;
  localparam int IDX_W_DEFAULT = $clog2(DEPTH_DEFAULT);

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with write enable and a registered read port.
// Only the read register is reset; the array keeps its contents across reset.
module ram_sp_64x32 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst && en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on a completed load, so it holds between loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Req/ack responder for CPU loads and stores into a word RAM, adding LATENCY
// wait states and rejecting misaligned or out-of-range byte addresses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = idx_width(DEPTH);

  state_t             state;
  state_t             state_nxt;
  logic [LAT_W-1:0]   cnt;
  logic               cap_we;
  logic [31:0]        cap_addr;
  logic [31:0]        cap_wdata;
  logic               capture;
  logic               fire;
  logic               bad_addr;
  logic               ram_en;

  // Errors are judged on the captured address so late input changes cannot matter.
  assign bad_addr = (cap_addr[WORD_OFF_BITS-1:0] != '0) ||
                    ((cap_addr >> (IDX_W + WORD_OFF_BITS)) != 32'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    capture = (state == IDLE) && req;
    fire    = (state == WAIT) && (cnt == '0);
    ram_en  = fire && !bad_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      ack <= fire;
      err <= fire && bad_addr;
      if (capture) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cnt       <= LAT_W'(LATENCY);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  ram_sp_64x32 #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (cap_we),
    .addr  (cap_addr[IDX_W+WORD_OFF_BITS-1:WORD_OFF_BITS]),
    .wdata (cap_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 and LATENCY=0) driven with directed
// and random traffic, checked against a byte-address memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, ack, err, busy;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m [2][64];
  logic [31:0] rd_m  [2];
  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;

  always @(posedge clk) cyc++;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic check_ack(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_ack dut%0d: got ack=1 expected none (cycle %0d)", d, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      cmp("ack_cycle", d, cyc, e.cyc);
      cmp("err", d, {31'd0, err[d]}, {31'd0, e.err});
      cmp("rdata", d, rdata[d], e.rd);
    end
  endtask

  // Monitor: every ack is matched against the oldest expected response.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1) check_ack(d);
    end
  end

  // Reference behaviour from the address rules on plain byte addresses.
  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output logic [31:0] r);
    e = (a % 4 != 0) || (a >= 32'd256);
    if (!e) begin
      if (w) mem_m[d][a / 4] = wd;
      else   rd_m[d] = mem_m[d][a / 4];
    end
    r = rd_m[d];
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 63)) * 4;
    else if (r == 7) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'd256 + 32'($urandom_range(0, 1000)) * 4;
    else             return $urandom;
  endfunction

  task automatic wait_done(input int d, input bit corrupt, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (corrupt) begin
        addr[d]  = a ^ 32'h4;
        wdata[d] = ~wd;
      end
      if (ack[d] === 1'b1) break;
      n++;
    end
    req[d] = 1'b0;
    if (n == 40) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 40 cycles", d);
    end
  endtask

  // complete=0 leaves the request in flight, for abandon-by-reset scenarios.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input bit corrupt, input bit complete);
    exp_t e;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1;
    if (complete) begin
      e.cyc = cyc + lat(d) + 1;
      model(d, w, a, wd, e.err, e.rd);
      push(d, e);
      wait_done(d, corrupt, a, wd);
    end
  endtask

  task automatic b2b(input int d, input int n);
    exp_t        e;
    logic        w;
    logic [31:0] a, wd;
    for (int k = 0; k < n; k++) begin
      w  = 1'($urandom_range(0, 1));
      a  = rand_addr();
      wd = $urandom;
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      #1;
      e.cyc = cyc + lat(d) + 1;
      model(d, w, a, wd, e.err, e.rd);
      push(d, e);
      repeat (lat(d) + 2) @(posedge clk);
    end
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int d = 0; d < 2; d++) begin
      cmp({nm, "_ack"},   d, {31'd0, ack[d]},  32'd0);
      cmp({nm, "_err"},   d, {31'd0, err[d]},  32'd0);
      cmp({nm, "_busy"},  d, {31'd0, busy[d]}, 32'd0);
      cmp({nm, "_rdata"}, d, rdata[d],         32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req = '0; we = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; rd_m[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) issue(d, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1);

      issue(d, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
      issue(d, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
      issue(d, 1'b1, 32'hFC, 32'h12345678, 1'b0, 1'b1);
      issue(d, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b1);
      issue(d, 1'b0, 32'h102, 32'h0, 1'b0, 1'b1);
      issue(d, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b0, 1'b1);
      issue(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      issue(d, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b1);
      issue(d, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
      issue(d, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);

      // Store abandoned by a one-cycle reset while still waiting.
      issue(d, 1'b1, 32'h30, 32'h22222222, 1'b0, 1'b1);
      issue(d, 1'b1, 32'h30, 32'h11111111, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rd_m[0] = '0; rd_m[1] = '0;
      cmp("midrst_busy",  d, {31'd0, busy[d]}, 32'd0);
      cmp("midrst_ack",   d, {31'd0, ack[d]},  32'd0);
      cmp("midrst_rdata", d, rdata[d],         32'd0);
      repeat (5) @(negedge clk);
      issue(d, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1);

      b2b(d, 8);

      for (int i = 0; i < 150; i++) begin
        issue(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 1'b1);
      end
    end

    // Reset from a busy state must still land on the idle values.
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset2");
    rst = 1'b1;
    rd_m[0] = '0; rd_m[1] = '0;
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    cmp("pending_q", 0, 32'(q0.size()), 32'd0);
    cmp("pending_q", 1, 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU data-memory interface. It accepts load/store requests from a multi-cycle initiator over a req/ack handshake and services them from a 64×32 word-addressed RAM after a programmable number of wait states. It flags misaligned or out-of-range byte addresses. It sits between the MIPS core's address/store-data path and the data storage, replacing the zero-latency combinational memory when wait-state behaviour is needed.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two.
- LATENCY, 2: wait cycles inserted before each access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- req  in  1  request valid; initiator holds req/we/addr/wdata stable until ack.
- we  in  1  1 = store word, 0 = load word.
- addr  in  32  byte address.
- wdata  in  32  store data.
- ack  out  1  one-cycle completion pulse (registered).
- rdata  out  32  load data, valid while ack=1 and err=0; held until the next completed load.
- err  out  1  valid with ack; 1 = access rejected.
- busy  out  1  1 in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** if req=1, register we/addr/wdata, load cnt with LATENCY, and go to WAIT. Otherwise stay in IDLE.
- **WAIT:** if cnt≠0, decrement cnt. If cnt=0, perform the access, set ack=1, and go to RESP.
- **RESP:** ack=1 for exactly this cycle. Set ack=0 and go to IDLE. req is ignored in RESP.
- Word index = addr[log2(DEPTH)+1:2].
- **Error:** addr[1:0]≠0 or addr[31:log2(DEPTH)+2]≠0.
  - Sets err=1 with ack.
  - No RAM write occurs.
  - rdata is not updated.
- **Store:** RAM[index] ← captured wdata at the WAIT→RESP edge.
- **Load:** rdata ← RAM[index] at the same edge.
- Request inputs are captured only on the IDLE→WAIT edge. Changes to inputs after capture have no effect.
- **Reset (rst=0):**
  - State returns to IDLE.
  - ack=0, err=0, busy=0, rdata=0, cnt=0.
  - RAM contents are not cleared.
- **Reset mid-transaction:** the transaction is abandoned with no ack. A store that has not reached the WAIT→RESP edge is not written.
- Reset takes precedence over every other event in the same cycle.

## Timing
- Request sampled at edge E0 → ack high in the cycle following edge E(LATENCY+1).
- Latency is LATENCY+1 cycles in every case:
  - LATENCY=0 gives 1 cycle.
  - Stores, loads and error responses all have the same latency.
- The earliest next request is sampled at edge E(LATENCY+3). Peak throughput is one access per LATENCY+3 cycles.
- If the initiator keeps req=1 through RESP, the values present at E(LATENCY+3) are taken as a new request (back-to-back allowed).
- busy rises the cycle after E0 and falls the cycle after RESP.
- Write is visible to a load issued by the immediately following transaction.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - Address-field constants (word-offset bits, index width derived from DEPTH).
  - LATENCY width constant (4 bits).
- One natural sub-module: `ram_sp_64x32`, a single-port synchronous RAM with write-enable and registered read, instantiated once. The FSM, counter and error check stay in the top.

## Test plan
- **Basic store/load, LATENCY=2:**
  - Store 0xDEADBEEF to addr 0x0000_0010 → ack 3 cycles after the req edge, err=0.
  - Load from 0x10 → rdata=0xDEADBEEF with ack, 3 cycles after its req edge.
- **LATENCY=0:**
  - Store 0x12345678 to 0xFC (last word), then load → ack 1 cycle after each request, rdata=0x12345678.
  - Back-to-back req held high → accepted every 3 cycles.
- **Errors:**
  - Load 0x0000_0102 → ack with err=1, rdata unchanged.
  - Store 0x0000_0100 with wdata 0xFFFFFFFF → err=1.
  - A subsequent load of 0x00 returns its prior contents.
- **Input stability:**
  - Change addr/wdata during WAIT after capturing a store of 0xA5A5A5A5 to 0x20 → 0x20 holds 0xA5A5A5A5.
  - The new values are not written.
- **Reset mid-store:**
  - Assert rst=0 for one cycle during WAIT of a store of 0x11111111 to 0x30 (0x30 previously 0x22222222) → no ack, busy=0, rdata=0.
  - A subsequent load of 0x30 returns 0x22222222.
- **Reset values:** after rst=0 for 2 cycles → ack=0, err=0, busy=0, rdata=0, regardless of prior state.
